bvudiv_skolem_checker: RTL and testbench
========================================

# bvudiv_skolem_checker

Sequential exhaustive checker that sits directly downstream of a combinational bvudiv Skolem function under test. It drives every 2W-bit input assignment onto the candidate's inputs and samples the candidate's single output bit. It compares that bit against a golden quotient bit from an internal multi-cycle restoring divider, then reports pass/fail, the failure count and the first failing assignment. Used in the Skolem-function flow to sign off generated witnesses before they are committed.

## Interface
Parameters:
- W, 4, operand width; the candidate has 2W inputs.
- QBIT, 0, index of the quotient bit the candidate must produce (0 ≤ QBIT < W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a sweep; accepted only in IDLE or DONE.
- vec  out  2W  assignment driven to candidate inputs i0..i(2W-1), with vec[k] = ik.
- cand  in  1  candidate output, combinational from vec.
- busy  out  1  high from sweep acceptance until DONE entry.
- done  out  1  high in DONE; held until the next accepted start.
- pass  out  1  valid when done=1; 1 iff fail_cnt = 0.
- expected  out  1  golden bit registered at the last compare.
- fail_cnt  out  2W+1  number of mismatching assignments; cannot overflow.
- fail_vec  out  2W  first mismatching assignment; 0 if none.

## Operation
- Operands are taken from vec: dividend a = vec[W-1:0], divisor b = vec[2W-1:W]. The golden bit is (a udiv b)[QBIT].
- Division by zero follows SMT-LIB semantics: the quotient is all ones. The restoring algorithm must produce this naturally, with no special case.
- FSM states: IDLE, APPLY, DIV, CMP, DONE.
  - IDLE/DONE → APPLY on start. On this transition clear fail_cnt, fail_vec, pass and done, and set vec = 0.
  - APPLY (1 cycle): load remainder = 0, quotient shift register = a, divisor = b, step counter = W-1.
  - DIV (W cycles): each cycle shift {rem, q} left by one. If rem ≥ b, subtract b and set the quotient LSB to 1. Leave DIV when the step counter reaches 0.
  - CMP (1 cycle): expected ← q[QBIT]. On mismatch (cand ≠ q[QBIT]), increment fail_cnt; if fail_cnt was 0, latch fail_vec ← vec. Then:
    - if vec = all ones → DONE, with pass = (fail_cnt_next = 0);
    - otherwise vec ← vec+1 → APPLY.
- vec stays stable from APPLY through CMP of the same assignment. Sampling cand in CMP gives the candidate at least W+1 cycles to settle.
- start is ignored in APPLY, DIV and CMP.
- Remainder width is W+1 bits, so the compare and subtract never lose the carry.

## Timing
- Reset values: state IDLE, vec 0, busy 0, done 0, pass 0, expected 0, fail_cnt 0, fail_vec 0, all divider registers 0.
- Reset asserted mid-sweep aborts immediately (asynchronous). The block returns to IDLE and requires a fresh start.
- Per-assignment cost is W+2 cycles. A full sweep takes 2^(2W)·(W+2) cycles from the start-accept edge to done rising; for W=4 that is 1536 cycles.
- busy rises the cycle after start is accepted. busy falls and done rises on the same edge.
- A start sampled in the same cycle done is high begins a new sweep, and done falls on the next edge.

## Structure
- Shared package bvudiv_chk_pkg holds:
  - the state enum (IDLE, APPLY, DIV, CMP, DONE);
  - width helpers: VEC_W = 2W, CNT_W = 2W+1.
- One sub-module, udiv_restoring: a W-bit sequential restoring divider with load, step, quotient and remainder signals. The checker FSM sequences it.

## Test plan
- Candidate modelled by the bench as the exact golden function (W=4, QBIT=0) → done at cycle 1536, pass=1, fail_cnt=0, fail_vec=0x00.
- Candidate tied to 0 (W=4, QBIT=0) → fail_cnt=102, fail_vec=0x00 (a=0, b=0 gives quotient 15, odd), pass=0.
- Golden candidate inverted only at vec=0x5A → fail_cnt=1, fail_vec=0x5A, pass=0.
- Divide-by-zero: observe CMP for vec=0x07 (b=0, a=7) at every QBIT 0..3 → expected=1.
- rst pulsed at cycle 500 of a sweep → all outputs at reset values within the same cycle. A new start then completes in 1536 cycles with correct counts.
- start pulsed at cycles 10 and 700 of a sweep → both ignored, and the sweep ends at cycle 1536. A start while done=1 re-runs and clears fail_cnt and done on acceptance.

Source files
------------

// File: rtl/bvudiv_skolem_checker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bvudiv_chk_pkg : FSM state type and width helpers for the bvudiv checker
// rev 1.0
// ---------------------------------------------------------------------------
package bvudiv_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_APPLY = 3'd1,
      ST_DIV   = 3'd2,
      ST_CMP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Candidate input width: dividend and divisor side by side.
   function automatic int vec_w(input int w);
      return 2 * w;
   endfunction

   // One extra bit so a sweep where every assignment fails still fits.
   function automatic int cnt_w(input int w);
      return 2 * w + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bvudiv_skolem_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bvudiv_skolem_checker_if : control, candidate and result signals of checker
// rev 1.0
// ---------------------------------------------------------------------------
interface bvudiv_skolem_checker_if
   import bvudiv_chk_pkg::*;
#(
   parameter int W = 4
);
   localparam int c_vec_w = vec_w(W);
   localparam int c_cnt_w = cnt_w(W);

   logic                 start;
   logic [c_vec_w-1:0]   vec;
   logic                 cand;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic                 expected;
   logic [c_cnt_w-1:0]   fail_cnt;
   logic [c_vec_w-1:0]   fail_vec;

   modport master (
      output start, cand,
      input  vec, busy, done, pass, expected, fail_cnt, fail_vec
   );

   modport slave (
      input  start, cand,
      output vec, busy, done, pass, expected, fail_cnt, fail_vec
   );

endinterface
`default_nettype wire

// File: rtl/bvudiv_skolem_checker_udiv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// udiv_restoring : W-bit sequential restoring divider, one quotient bit/step
// rev 1.0
// ---------------------------------------------------------------------------
module udiv_restoring #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W:0]   remainder
);

   logic [W-1:0] r_divisor;
   logic [W:0]   w_rem_shift;
   logic [W:0]   w_rem_sub;
   logic         w_ge;

   // A zero divisor makes w_ge always true, so every quotient bit comes out 1.
   assign w_rem_shift = {remainder[W-1:0], quotient[W-1]};
   assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
   assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         r_divisor <= '0;
      end else if (load) begin
         quotient  <= dividend;
         remainder <= '0;
         r_divisor <= divisor;
      end else if (step) begin
         quotient  <= (quotient << 1) | W'(w_ge);
         remainder <= w_ge ? w_rem_sub : w_rem_shift;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bvudiv_skolem_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bvudiv_skolem_checker : exhaustive sweep of a bvudiv Skolem candidate bit
// rev 1.0
// ---------------------------------------------------------------------------
module bvudiv_skolem_checker
   import bvudiv_chk_pkg::*;
#(
   parameter int W    = 4,
   parameter int QBIT = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   bvudiv_skolem_checker_if.slave  chk
);

   localparam int           c_vec_w     = vec_w(W);
   localparam int           c_cnt_w     = cnt_w(W);
   localparam logic [W-1:0] c_qmask     = W'(1) << QBIT;
   localparam logic [W-1:0] c_step_init = W'(W - 1);

   state_t               r_state;
   logic [c_vec_w-1:0]   r_vec;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_pass;
   logic                 r_expected;
   logic [c_cnt_w-1:0]   r_fail_cnt;
   logic [c_vec_w-1:0]   r_fail_vec;
   logic [W-1:0]         r_step_cnt;

   logic                 w_div_load;
   logic                 w_div_step;
   logic [W-1:0]         w_div_quot;
   logic [W:0]           w_div_rem_unused;
   logic                 w_golden;
   logic                 w_mismatch;
   logic [c_cnt_w-1:0]   w_fail_cnt_next;

   assign w_div_load      = (r_state == ST_APPLY);
   assign w_div_step      = (r_state == ST_DIV);
   assign w_golden        = |(w_div_quot & c_qmask);
   assign w_mismatch      = (chk.cand != w_golden);
   assign w_fail_cnt_next = r_fail_cnt + c_cnt_w'(w_mismatch);

   udiv_restoring #(
      .W (W)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (w_div_load),
      .step      (w_div_step),
      .dividend  (r_vec[W-1:0]),
      .divisor   (r_vec[c_vec_w-1:W]),
      .quotient  (w_div_quot),
      .remainder (w_div_rem_unused)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_vec      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_expected <= 1'b0;
         r_fail_cnt <= '0;
         r_fail_vec <= '0;
         r_step_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (chk.start) begin
                  r_state    <= ST_APPLY;
                  r_vec      <= '0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_pass     <= 1'b0;
                  r_fail_cnt <= '0;
                  r_fail_vec <= '0;
               end
            end
            ST_APPLY: begin
               r_state    <= ST_DIV;
               r_step_cnt <= c_step_init;
            end
            ST_DIV: begin
               if (r_step_cnt == '0) begin
                  r_state <= ST_CMP;
               end else begin
                  r_step_cnt <= r_step_cnt - W'(1);
               end
            end
            ST_CMP: begin
               r_expected <= w_golden;
               if (w_mismatch) begin
                  r_fail_cnt <= w_fail_cnt_next;
                  // Only the first failing assignment is kept.
                  if (r_fail_cnt == '0) begin
                     r_fail_vec <= r_vec;
                  end
               end
               if (&r_vec) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_fail_cnt_next == '0);
               end else begin
                  r_vec   <= r_vec + c_vec_w'(1);
                  r_state <= ST_APPLY;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign chk.vec      = r_vec;
   assign chk.busy     = r_busy;
   assign chk.done     = r_done;
   assign chk.pass     = r_pass;
   assign chk.expected = r_expected;
   assign chk.fail_cnt = r_fail_cnt;
   assign chk.fail_vec = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_bvudiv_skolem_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bvudiv_skolem_checker : scoreboard bench, directed sweeps for W=4
// rev 1.0
// ---------------------------------------------------------------------------
module tb_bvudiv_skolem_checker;

   localparam int W     = 4;
   localparam int SWEEP = 1536;

   typedef struct {
      logic       pass;
      logic [8:0] cnt;
      logic [7:0] fv;
      int         acc;
   } exp_t;

   exp_t sb[$];

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   int   mode  = 0;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic golden_bit(input logic [7:0] v, input int qb);
      logic [3:0] a, b, q;
      a = v[3:0];
      b = v[7:4];
      q = (b == 4'd0) ? 4'hF : (a / b);
      return q[qb];
   endfunction

   // mode 0: exact golden, 1: tied low, 2: golden inverted only at 0x5A
   function automatic logic cand_model(input logic [7:0] v, input int m);
      case (m)
         1:       return 1'b0;
         2:       return golden_bit(v, 0) ^ (v == 8'h5A);
         default: return golden_bit(v, 0);
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   bvudiv_skolem_checker_if #(.W(W)) bus ();

   bvudiv_skolem_checker #(.W(W), .QBIT(0)) dut (
      .clk (clk),
      .rst (rst),
      .chk (bus)
   );

   assign bus.start = start;
   assign bus.cand  = cand_model(bus.vec, mode);

   // Extra checkers for the other quotient bits, each fed an exact candidate.
   for (genvar q = 1; q < W; q++) begin : g_aux
      bvudiv_skolem_checker_if #(.W(W)) abus ();
      bvudiv_skolem_checker #(.W(W), .QBIT(q)) adut (
         .clk (clk),
         .rst (rst),
         .chk (abus)
      );
      assign abus.start = start;
      assign abus.cand  = golden_bit(abus.vec, q);

      logic [7:0] vec_prev;
      logic       done_prev;
      always @(negedge clk) begin
         if (vec_prev == 8'h07 && abus.vec == 8'h08)
            check($sformatf("div0_expected_q%0d", q), abus.expected, 1);
         if (abus.done && !done_prev) begin
            check($sformatf("aux_pass_q%0d", q), abus.pass, 1);
            check($sformatf("aux_fail_cnt_q%0d", q), abus.fail_cnt, 0);
         end
         vec_prev  <= abus.vec;
         done_prev <= abus.done;
      end
   end

   // Scoreboard monitor for the main checker.
   logic [7:0] vec_prev0;
   logic       done_prev0 = 1'b0;
   always @(negedge clk) begin
      if (vec_prev0 == 8'h07 && bus.vec == 8'h08)
         check("div0_expected_q0", bus.expected, 1);
      if (bus.done && !done_prev0) begin
         check("sb_nonempty", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pass",     bus.pass,     e.pass);
            check("fail_cnt", bus.fail_cnt, e.cnt);
            check("fail_vec", bus.fail_vec, e.fv);
            check("busy_low", bus.busy,     0);
            check("latency",  cyc - e.acc,  SWEEP);
         end
      end
      vec_prev0  <= bus.vec;
      done_prev0 <= bus.done;
   end

   task automatic check_reset(input string tag);
      check({tag, "_vec"},      bus.vec,      0);
      check({tag, "_busy"},     bus.busy,     0);
      check({tag, "_done"},     bus.done,     0);
      check({tag, "_pass"},     bus.pass,     0);
      check({tag, "_expected"}, bus.expected, 0);
      check({tag, "_fail_cnt"}, bus.fail_cnt, 0);
      check({tag, "_fail_vec"}, bus.fail_vec, 0);
   endtask

   // Called at a negedge; returns 1 ns after the accepting edge.
   task automatic launch(input int m, input bit push, input logic p,
                         input int cnt, input int fv);
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) sb.push_back('{p, 9'(cnt), 8'(fv), cyc});
      check("accept_busy",     bus.busy,     1);
      check("accept_done",     bus.done,     0);
      check("accept_fail_cnt", bus.fail_cnt, 0);
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!bus.done && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check({name, "_done_seen"}, bus.done, 1);
      @(negedge clk);
   endtask

   task automatic pulse_start_at(input int n);
      repeat (n - 1) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      launch(0, 1'b1, 1'b1, 0, 8'h00);
      wait_done("golden");

      launch(1, 1'b1, 1'b0, 102, 8'h00);
      wait_done("tied0");

      launch(2, 1'b1, 1'b0, 1, 8'h5A);
      wait_done("inv5a");

      // Abort mid-sweep with an asynchronous reset pulse.
      launch(0, 1'b0, 1'b0, 0, 0);
      repeat (500) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      launch(1, 1'b1, 1'b0, 102, 8'h00);
      wait_done("after_rst");

      // Restart from DONE, with stray starts mid-sweep that must be ignored.
      launch(0, 1'b1, 1'b1, 0, 8'h00);
      pulse_start_at(10);
      check("busy_after_stray_start", bus.busy, 1);
      pulse_start_at(690);
      wait_done("stray_start");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
